mult_requester: RTL and testbench

MULT_REQUESTER -- requirements
Module: mult_requester

---
 rtl/mult_req_pkg.sv | 21 ++
 rtl/mult_req_fifo.sv | 67 ++++++
 rtl/mult_requester.sv | 150 +++++++++++++++
 tb/tb_mult_requester.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_req_pkg.sv
// Shared definitions for the multiplier requester: FSM state encoding,
// default parameter values and the operand buffer depth.
package mult_req_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        REQ       = 2'b01,
        WAIT_DONE = 2'b10,
        RESULT    = 2'b11
    } state_e;

    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 16;
    localparam int FIFO_DEPTH  = 2;

    // Bits needed to index n items (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_req_fifo.sv
// Small operand buffer with full/empty flags. A push and a pop in the same
// cycle leave the occupancy unchanged. Pushes while full and pops while empty
// are dropped.
module mult_req_fifo
    import mult_req_pkg::*;
#(
    parameter int WIDTH = 2 * DATA_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = cnt_width(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Next pointer and occupancy values from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    // Pointer/occupancy registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Operand storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mult_requester.sv
// Buffers operand pairs and drives a start/ack/done handshake to an external
// multiplier, with a timeout on both the ack and the done phase. Each
// transaction produces exactly one downstream result (product or error).
module mult_requester
    import mult_req_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    output logic                mult_start,
    output logic [DATA_W-1:0]   mult_a,
    output logic [DATA_W-1:0]   mult_b,
    input  logic                mult_ack,
    input  logic                mult_locked,
    input  logic                mult_done,
    input  logic [2*DATA_W-1:0] mult_product,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_product,
    output logic                out_err,
    output logic                busy
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  start_q;
    logic [DATA_W-1:0]     a_q, b_q;
    logic                  out_valid_q;
    logic [2*DATA_W-1:0]   prod_q;
    logic                  err_q;
    logic                  accept_en_q;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*DATA_W-1:0]   fifo_head;
    logic [DATA_W-1:0]     head_a, head_b;
    logic                  timed_out;

    assign timed_out = (cnt_q == CNT_LAST);
    assign fifo_push = in_valid && in_ready;
    // The buffered pair is released only once its transaction has finished,
    // either with a product or with a timeout error.
    assign fifo_pop  = ((state_q == REQ) && !mult_ack && timed_out) ||
                       ((state_q == WAIT_DONE) && (mult_done || timed_out));

    mult_req_fifo #(
        .WIDTH (2 * DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({in_a, in_b}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_a, head_b} = fifo_head;

    // Hold off upstream until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) accept_en_q <= 1'b0;
        else      accept_en_q <= 1'b1;
    end

    assign in_ready    = accept_en_q && !fifo_full;
    assign busy        = !fifo_empty || (state_q != IDLE);
    assign mult_start  = start_q;
    assign mult_a      = a_q;
    assign mult_b      = b_q;
    assign out_valid   = out_valid_q;
    assign out_product = prod_q;
    assign out_err     = err_q;

    // Request sequencer with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            prod_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Waiting on mult_locked keeps us off a multiplier that
                    // is still finishing the previous job.
                    if (!fifo_empty && !mult_locked) begin
                        state_q <= REQ;
                        start_q <= 1'b1;
                        a_q     <= head_a;
                        b_q     <= head_b;
                        cnt_q   <= '0;
                    end
                end
                REQ: begin
                    if (mult_ack) begin
                        state_q <= WAIT_DONE;
                        start_q <= 1'b0;
                        cnt_q   <= '0;
                    end else if (timed_out) begin
                        state_q     <= RESULT;
                        start_q     <= 1'b0;
                        out_valid_q <= 1'b1;
                        prod_q      <= '0;
                        err_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    // A done arriving on the timeout cycle still counts.
                    if (mult_done) begin
                        state_q     <= RESULT;
                        out_valid_q <= 1'b1;
                        prod_q      <= mult_product;
                        err_q       <= 1'b0;
                    end else if (timed_out) begin
                        state_q     <= RESULT;
                        out_valid_q <= 1'b1;
                        prod_q      <= '0;
                        err_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_requester.sv
// Self-checking bench for mult_requester: a behavioural multiplier responder
// plus a queue-based reference of expected results.
module tb_mult_requester;

    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct {
        int prod;
        bit err;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0, in_b = '0;
    logic          mult_start;
    logic [DW-1:0] mult_a, mult_b;
    logic          mult_ack = 1'b0, mult_locked = 1'b0, mult_done = 1'b0;
    logic [2*DW-1:0] mult_product = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2*DW-1:0] out_product;
    logic          out_err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    res_t exp_q[$];
    res_t got_q[$];

    // Multiplier responder configuration
    int cfg_ack_lat = 0, cfg_done_lat = 4, cfg_finish = 1;
    bit cfg_never_ack = 0, cfg_rand = 0;
    int m_st = 0, m_cnt = 0, cur_ack = 0, cur_done = 4;
    logic [DW-1:0] m_a, m_b;

    // Start-line observations
    int  start_viol = 0;
    bit  prev_start = 0, prev_locked = 0;

    always #5 clk = ~clk;

    mult_requester #(
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_ack     (mult_ack),
        .mult_locked  (mult_locked),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .out_err      (out_err),
        .busy         (busy)
    );

    // Multiplier model: acks after cur_ack cycles of start, done cur_done
    // cycles after ack, stays locked cfg_finish cycles after done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mult_ack  = 1'b0;
            mult_done = 1'b0;
            case (m_st)
                0: begin
                    if (mult_start && !cfg_never_ack) begin
                        if (m_cnt == 0) begin
                            cur_ack  = cfg_rand ? int'($urandom_range(0, 3)) : cfg_ack_lat;
                            cur_done = cfg_rand ? int'($urandom_range(1, 6)) : cfg_done_lat;
                        end
                        if (m_cnt >= cur_ack) begin
                            mult_ack    = 1'b1;
                            mult_locked = 1'b1;
                            m_a = mult_a;
                            m_b = mult_b;
                            m_st = 1;
                            m_cnt = 0;
                        end else begin
                            m_cnt++;
                        end
                    end else begin
                        m_cnt = 0;
                    end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt >= cur_done) begin
                        mult_done    = 1'b1;
                        mult_product = (2*DW)'(m_a) * (2*DW)'(m_b);
                        m_st = 2;
                        m_cnt = 0;
                    end
                end
                default: begin
                    m_cnt++;
                    if (m_cnt >= cfg_finish) begin
                        mult_locked = 1'b0;
                        m_st = 0;
                        m_cnt = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: collects handshaken results and watches start vs locked.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                r.prod = int'(out_product);
                r.err  = out_err;
                got_q.push_back(r);
            end
            if (mult_start && !prev_start && prev_locked) start_viol++;
            prev_start  = mult_start;
            prev_locked = mult_locked;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_pair(input int a, input int b, input bit err);
        int n = 0;
        res_t r;
        in_a = DW'(a);
        in_b = DW'(b);
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin step(); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL push_wait: in_ready got 0 expected 1");
        end else begin
            r.prod = err ? 0 : a * b;
            r.err  = err;
            exp_q.push_back(r);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while ((busy || mult_locked || m_st != 0) && n < 300) begin step(); n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL settle_busy: got %0b expected 0", busy); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %0b expected 0", in_ready); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        checks++; if (mult_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %0b expected 0", mult_start); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_product !== '0 || out_err !== 1'b0 || mult_a !== '0 || mult_b !== '0)
            begin errors++; $display("FAIL rst_data: prod %0d err %0b a %0d b %0d expected all 0", out_product, out_err, mult_a, mult_b); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL rel_in_ready_early: got %0b expected 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rel_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        int n = 0;
        out_ready = 1'b1;
        push_pair(3, 5, 0);
        checks++; if (mult_start !== 1'b0) begin errors++; $display("FAIL basic_start_early: got %0b expected 0", mult_start); end
        step();
        checks++; if (mult_start !== 1'b1) begin errors++; $display("FAIL basic_start: got %0b expected 1", mult_start); end
        checks++; if (mult_a !== 8'd3 || mult_b !== 8'd5) begin errors++; $display("FAIL basic_operands: got %0d,%0d expected 3,5", mult_a, mult_b); end
        step();
        checks++; if (mult_start !== 1'b0) begin errors++; $display("FAIL basic_start_len: got %0b expected 0", mult_start); end
        while (!mult_done && n < 50) begin step(); n++; end
        checks++; if (mult_done !== 1'b1) begin errors++; $display("FAIL basic_done_wait: got %0b expected 1", mult_done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %0b expected 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b expected 1", out_valid); end
        checks++; if (out_product !== 16'd15 || out_err !== 1'b0) begin errors++; $display("FAIL basic_result: got %0d err %0b expected 15 err 0", out_product, out_err); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b expected 0", out_valid); end
        settle();
    endtask

    task automatic test_backpressure();
        int n = 0;
        out_ready = 1'b0;
        push_pair(255, 255, 0);
        while (!out_valid && n < 60) begin step(); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_product !== 16'd65025 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid %0b prod %0d err %0b expected 1 65025 0", i, out_valid, out_product, out_err);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %0b expected 0", out_valid); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL bp_count: got %0d expected 1", got_q.size()); end
        settle();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        res_t r;
        out_ready = 1'b1;
        cfg_finish = 3;
        start_viol = 0;
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd2;
        r.prod = 2; r.err = 0; exp_q.push_back(r);
        step();
        in_a = 8'd3; in_b = 8'd4;
        r.prod = 12; exp_q.push_back(r);
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: in_ready got %0b expected 0", in_ready); end
        in_a = 8'd5; in_b = 8'd6;
        while (!in_ready && n < 100) begin step(); n++; end
        r.prod = 30; exp_q.push_back(r);
        step();
        in_valid = 1'b0;
        n = 0;
        while (got_q.size() < 3 && n < 300) begin step(); n++; end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got_q.size()) begin
                errors++; $display("FAIL b2b_result[%0d]: got none expected %0d", i, exp_q[i].prod);
            end else if (got_q[i].prod != exp_q[i].prod || got_q[i].err != exp_q[i].err) begin
                errors++; $display("FAIL b2b_result[%0d]: got %0d err %0b expected %0d err 0", i, got_q[i].prod, got_q[i].err, exp_q[i].prod);
            end
        end
        checks++; if (start_viol != 0) begin errors++; $display("FAIL b2b_locked_start: got %0d expected 0", start_viol); end
        settle();
        cfg_finish = 1;
    endtask

    task automatic test_timeout();
        int n = 0;
        int hi = 0;
        out_ready = 1'b0;
        cfg_never_ack = 1;
        push_pair(7, 9, 1);
        push_pair(2, 3, 1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL to_full: in_ready got %0b expected 0", in_ready); end
        while (!out_valid && n < 60) begin
            if (mult_start) hi++;
            step(); n++;
        end
        checks++; if (hi != TO) begin errors++; $display("FAIL to_req_cycles: got %0d expected %0d", hi, TO); end
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_product !== '0)
            begin errors++; $display("FAIL to_result: valid %0b err %0b prod %0d expected 1 1 0", out_valid, out_err, out_product); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL to_pop: in_ready %0b busy %0b expected 1 1", in_ready, busy); end
        out_ready = 1'b1;
        n = 0;
        while (got_q.size() < 2 && n < 100) begin step(); n++; end
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL to_count: got %0d expected 2", got_q.size()); end
        else if (got_q[1].err != 1'b1 || got_q[1].prod != 0) begin errors++; $display("FAIL to_second: got %0d err %0b expected 0 err 1", got_q[1].prod, got_q[1].err); end
        cfg_never_ack = 0;
        settle();
    endtask

    task automatic test_coincide();
        int n = 0;
        out_ready = 1'b1;
        cfg_done_lat = TO;
        push_pair(11, 13, 0);
        while (got_q.size() < 1 && n < 100) begin step(); n++; end
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL tie_count: got %0d expected 1", got_q.size()); end
        else if (got_q[0].prod != 143 || got_q[0].err != 1'b0) begin errors++; $display("FAIL tie_result: got %0d err %0b expected 143 err 0", got_q[0].prod, got_q[0].err); end
        settle();
        cfg_done_lat = TO + 1;
        push_pair(6, 7, 1);
        n = 0;
        while (got_q.size() < 1 && n < 100) begin step(); n++; end
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL late_count: got %0d expected 1", got_q.size()); end
        else if (got_q[0].prod != 0 || got_q[0].err != 1'b1) begin errors++; $display("FAIL late_result: got %0d err %0b expected 0 err 1", got_q[0].prod, got_q[0].err); end
        repeat (30) step();
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL late_ignored: got %0d results expected 1", got_q.size()); end
        cfg_done_lat = 4;
        settle();
    endtask

    task automatic test_random();
        int   sent = 0;
        int   n = 0;
        bit   hold = 0;
        logic [2*DW-1:0] hp;
        logic he;
        res_t r;
        cfg_rand = 1;
        start_viol = 0;
        while ((sent < 24 || got_q.size() < 24) && n < 3000) begin
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_product !== hp || out_err !== he) begin
                    errors++;
                    $display("FAIL rnd_hold: valid %0b prod %0d err %0b expected 1 %0d %0b", out_valid, out_product, out_err, hp, he);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 24 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                in_a = DW'($urandom);
                in_b = DW'($urandom);
                if (in_ready) begin
                    r.prod = int'(in_a) * int'(in_b);
                    r.err  = 0;
                    exp_q.push_back(r);
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
            hold = out_valid && !out_ready;
            hp = out_product;
            he = out_err;
            step(); n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size()) begin
                errors++; $display("FAIL rnd_result[%0d]: got none expected %0d", i, exp_q[i].prod);
            end else if (got_q[i].prod != exp_q[i].prod || got_q[i].err != 1'b0) begin
                errors++; $display("FAIL rnd_result[%0d]: got %0d err %0b expected %0d err 0", i, got_q[i].prod, got_q[i].err, exp_q[i].prod);
            end
        end
        checks++; if (got_q.size() != 24) begin errors++; $display("FAIL rnd_count: got %0d expected 24", got_q.size()); end
        checks++; if (start_viol != 0) begin errors++; $display("FAIL rnd_locked_start: got %0d expected 0", start_viol); end
        cfg_rand = 0;
        settle();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int vcount = 0;
        out_ready = 1'b1;
        cfg_done_lat = 8;
        push_pair(9, 9, 0);
        push_pair(8, 8, 0);
        while (!mult_ack && n < 50) begin step(); n++; end
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: in_ready got %0b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (mult_start !== 1'b0 || mult_a !== '0 || mult_b !== '0)
            begin errors++; $display("FAIL mid_rst_req: start %0b a %0d b %0d expected 0 0 0", mult_start, mult_a, mult_b); end
        checks++; if (out_valid !== 1'b0 || out_product !== '0 || out_err !== 1'b0)
            begin errors++; $display("FAIL mid_rst_out: valid %0b prod %0d err %0b expected 0 0 0", out_valid, out_product, out_err); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0)
            begin errors++; $display("FAIL mid_rst_flags: busy %0b in_ready %0b expected 0 0", busy, in_ready); end
        step();
        step();
        rst = 1'b1;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            if (out_valid) vcount++;
            step();
        end
        checks++; if (vcount != 0 || got_q.size() != 0) begin errors++; $display("FAIL mid_no_result: got %0d valid cycles expected 0", vcount); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: busy got %0b expected 0", busy); end
        cfg_done_lat = 4;
        push_pair(4, 4, 0);
        n = 0;
        while (got_q.size() < 1 && n < 100) begin step(); n++; end
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL mid_after: got %0d results expected 1", got_q.size()); end
        else if (got_q[0].prod != 16 || got_q[0].err != 1'b0) begin errors++; $display("FAIL mid_after: got %0d err %0b expected 16 err 0", got_q[0].prod, got_q[0].err); end
        settle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_coincide();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
